pixel_buffer: RTL and testbench

PIXEL_BUFFER -- requirements
Module: pixel_buffer

---
 rtl/pixel_buffer.sv | 160 ++++++++++++++++
 tb/tb_pixel_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_buffer
// Function : Two-bank ping-pong RGB pixel buffer; 4-lane byte writes, 3-byte pixel reads.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_buffer #(
    parameter int P_BANK_BYTES = 192,
    parameter int P_BEATS      = 48
) (
    input  logic        I_PB_HCLK,
    input  logic        I_PB_HRESET,
    input  logic        I_PB_WR_EN,
    input  logic [7:0]  I_PB_WR_ADDR0,
    input  logic [7:0]  I_PB_WR_ADDR1,
    input  logic [7:0]  I_PB_WR_ADDR2,
    input  logic [7:0]  I_PB_WR_ADDR3,
    input  logic [31:0] I_PB_WR_DATA,
    input  logic        I_PB_WR_DONE,
    input  logic        I_PB_RD_EN,
    input  logic [7:0]  I_PB_RD_ADDRR,
    input  logic [7:0]  I_PB_RD_ADDRG,
    input  logic [7:0]  I_PB_RD_ADDRB,
    input  logic        I_PB_RD_DONE,
    output logic [23:0] O_PB_RD_DATA,
    output logic        O_PB_RD_VALID,
    output logic        O_PB_WR_READY,
    output logic        O_PB_RD_READY,
    output logic [5:0]  O_PB_WR_COUNT,
    output logic        O_PB_ERR
);

    localparam int          C_MEM_DEPTH = 2 * P_BANK_BYTES;
    localparam int          C_MEM_AW    = $clog2(C_MEM_DEPTH);
    localparam logic [5:0]  C_BEATS     = 6'(P_BEATS);

    logic [7:0]          mem_q [C_MEM_DEPTH];
    logic                wr_sel_q, wr_sel_d;
    logic                rd_sel_q, rd_sel_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic [5:0]          wr_count_q, wr_count_d;
    logic [23:0]         rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;

    logic                w_wr_ready, w_rd_ready;
    logic                w_wr_acc, w_rd_acc, w_wr_close, w_rd_rel;
    logic [7:0]          w_wr_addr [4];
    logic [3:0]          w_wr_ok;
    logic [7:0]          w_rd_addr [3];
    logic [2:0]          w_rd_ok;
    logic [C_MEM_AW-1:0] w_rd_idx  [3];
    logic [7:0]          w_rd_byte [3];

    // Bank 1 occupies the upper half of the flat byte array.
    function automatic logic [C_MEM_AW-1:0] f_mem_idx(input logic sel, input logic [7:0] addr);
        return C_MEM_AW'(addr) + (sel ? C_MEM_AW'(P_BANK_BYTES) : '0);
    endfunction

    assign w_wr_ready = ~bank_full_q[wr_sel_q];
    assign w_rd_ready = bank_full_q[rd_sel_q];
    assign w_wr_acc   = I_PB_WR_EN   & w_wr_ready;
    assign w_rd_acc   = I_PB_RD_EN   & w_rd_ready;
    assign w_wr_close = I_PB_WR_DONE & w_wr_ready;
    assign w_rd_rel   = I_PB_RD_DONE & w_rd_ready;

    always_comb begin
        w_wr_addr[0] = I_PB_WR_ADDR0;
        w_wr_addr[1] = I_PB_WR_ADDR1;
        w_wr_addr[2] = I_PB_WR_ADDR2;
        w_wr_addr[3] = I_PB_WR_ADDR3;
        w_rd_addr[0] = I_PB_RD_ADDRR;
        w_rd_addr[1] = I_PB_RD_ADDRG;
        w_rd_addr[2] = I_PB_RD_ADDRB;
        for (int l = 0; l < 4; l++) begin
            w_wr_ok[l] = int'(w_wr_addr[l]) < P_BANK_BYTES;
        end
        for (int c = 0; c < 3; c++) begin
            w_rd_ok[c]   = int'(w_rd_addr[c]) < P_BANK_BYTES;
            w_rd_idx[c]  = w_rd_ok[c] ? f_mem_idx(rd_sel_q, w_rd_addr[c]) : '0;
            w_rd_byte[c] = w_rd_ok[c] ? mem_q[w_rd_idx[c]] : 8'h00;
        end
    end

    always_comb begin
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        bank_full_d = bank_full_q;
        wr_count_d  = wr_count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        if (w_wr_acc && (wr_count_q < C_BEATS)) begin
            wr_count_d = wr_count_q + 6'd1;
        end
        // A closing bank and a releasing bank are always distinct, so both may update.
        if (w_wr_close) begin
            bank_full_d[wr_sel_q] = 1'b1;
            wr_sel_d              = ~wr_sel_q;
            wr_count_d            = '0;
        end
        if (w_rd_rel) begin
            bank_full_d[rd_sel_q] = 1'b0;
            rd_sel_d              = ~rd_sel_q;
        end

        if (w_rd_acc) begin
            rd_data_d  = {w_rd_byte[0], w_rd_byte[1], w_rd_byte[2]};
            rd_valid_d = 1'b1;
        end else if (I_PB_RD_EN) begin
            rd_data_d  = '0;
        end

        err_d = err_q
              | (I_PB_WR_EN   & ~w_wr_ready)
              | (w_wr_acc     & ~(&w_wr_ok))
              | (I_PB_WR_DONE & ~w_wr_ready)
              | (I_PB_RD_EN   & ~w_rd_ready)
              | (w_rd_acc     & ~(&w_rd_ok))
              | (I_PB_RD_DONE & ~w_rd_ready);
    end

    always_ff @(posedge I_PB_HCLK) begin
        if (I_PB_HRESET) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            bank_full_q <= '0;
            wr_count_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            bank_full_q <= bank_full_d;
            wr_count_q  <= wr_count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
        end
    end

    // Pixel storage carries no reset; only status is discarded.
    always_ff @(posedge I_PB_HCLK) begin
        for (int l = 0; l < 4; l++) begin
            if (!I_PB_HRESET && w_wr_acc && w_wr_ok[l]) begin
                mem_q[f_mem_idx(wr_sel_q, w_wr_addr[l])] <= I_PB_WR_DATA[8*l +: 8];
            end
        end
    end

    assign O_PB_RD_DATA  = rd_data_q;
    assign O_PB_RD_VALID = rd_valid_q;
    assign O_PB_WR_READY = w_wr_ready;
    assign O_PB_RD_READY = w_rd_ready;
    assign O_PB_WR_COUNT = wr_count_q;
    assign O_PB_ERR      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_buffer
// Function : Self-checking bench for pixel_buffer against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_buffer;

    localparam int C_BYTES = 192;
    localparam int C_BEATS = 48;

    logic        clk;
    logic        rst;
    logic        wr_en, wr_done, rd_en, rd_done;
    logic [7:0]  wa0, wa1, wa2, wa3;
    logic [31:0] wd;
    logic [7:0]  ra_r, ra_g, ra_b;
    logic [23:0] rd_data;
    logic        rd_valid, wr_ready, rd_ready, err;
    logic [5:0]  wr_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [7:0]  mdl_mem   [2][C_BYTES];
    bit          mdl_known [2][C_BYTES];
    bit          mdl_wsel, mdl_rsel;
    bit [1:0]    mdl_full;
    int          mdl_count;
    bit          mdl_err, mdl_vld, mdl_dknown;
    logic [23:0] mdl_data;

    pixel_buffer #(.P_BANK_BYTES(C_BYTES), .P_BEATS(C_BEATS)) u_dut (
        .I_PB_HCLK     (clk),
        .I_PB_HRESET   (rst),
        .I_PB_WR_EN    (wr_en),
        .I_PB_WR_ADDR0 (wa0),
        .I_PB_WR_ADDR1 (wa1),
        .I_PB_WR_ADDR2 (wa2),
        .I_PB_WR_ADDR3 (wa3),
        .I_PB_WR_DATA  (wd),
        .I_PB_WR_DONE  (wr_done),
        .I_PB_RD_EN    (rd_en),
        .I_PB_RD_ADDRR (ra_r),
        .I_PB_RD_ADDRG (ra_g),
        .I_PB_RD_ADDRB (ra_b),
        .I_PB_RD_DONE  (rd_done),
        .O_PB_RD_DATA  (rd_data),
        .O_PB_RD_VALID (rd_valid),
        .O_PB_WR_READY (wr_ready),
        .O_PB_RD_READY (rd_ready),
        .O_PB_WR_COUNT (wr_count),
        .O_PB_ERR      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mdl_read(input int addr, output bit known);
        if (addr >= C_BYTES) begin
            mdl_err = 1'b1;
            known   = 1'b1;
            return 8'h00;
        end
        known = mdl_known[mdl_rsel][addr];
        return mdl_mem[mdl_rsel][addr];
    endfunction

    task automatic model_update();
        bit   wrdy, rrdy, k0, k1, k2;
        int   la [4];
        logic [7:0] b0, b1, b2;
        if (rst) begin
            mdl_wsel = 0; mdl_rsel = 0; mdl_full = 0; mdl_count = 0;
            mdl_err = 0; mdl_vld = 0; mdl_data = 0; mdl_dknown = 1;
            return;
        end
        wrdy = !mdl_full[mdl_wsel];
        rrdy = mdl_full[mdl_rsel];
        la[0] = wa0; la[1] = wa1; la[2] = wa2; la[3] = wa3;
        if (wr_en && wrdy) begin
            for (int l = 0; l < 4; l++) begin
                if (la[l] < C_BYTES) begin
                    mdl_mem[mdl_wsel][la[l]]   = wd[8*l +: 8];
                    mdl_known[mdl_wsel][la[l]] = 1;
                end else begin
                    mdl_err = 1;
                end
            end
            if (mdl_count < C_BEATS) mdl_count++;
        end else if (wr_en) begin
            mdl_err = 1;
        end
        mdl_vld = 0;
        if (rd_en && rrdy) begin
            b0 = mdl_read(int'(ra_r), k0);
            b1 = mdl_read(int'(ra_g), k1);
            b2 = mdl_read(int'(ra_b), k2);
            mdl_data   = {b0, b1, b2};
            mdl_dknown = k0 && k1 && k2;
            mdl_vld    = 1;
        end else if (rd_en) begin
            mdl_data = 0; mdl_dknown = 1; mdl_err = 1;
        end
        if (wr_done) begin
            if (wrdy) begin
                mdl_full[mdl_wsel] = 1; mdl_wsel = !mdl_wsel; mdl_count = 0;
            end else mdl_err = 1;
        end
        if (rd_done) begin
            if (rrdy) begin
                mdl_full[mdl_rsel] = 0; mdl_rsel = !mdl_rsel;
            end else mdl_err = 1;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("wr_ready", 32'(wr_ready), 32'(!mdl_full[mdl_wsel]));
        check("rd_ready", 32'(rd_ready), 32'(mdl_full[mdl_rsel]));
        check("wr_count", 32'(wr_count), 32'(mdl_count));
        check("err",      32'(err),      32'(mdl_err));
        check("rd_valid", 32'(rd_valid), 32'(mdl_vld));
        if (mdl_dknown) check("rd_data", 32'(rd_data), 32'(mdl_data));
    endtask

    task automatic idle();
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        wa0 = 0; wa1 = 0; wa2 = 0; wa3 = 0; wd = 0;
        ra_r = 0; ra_g = 0; ra_b = 0;
    endtask

    task automatic beat(input logic [7:0] a0, a1, a2, a3, input logic [31:0] d);
        wr_en = 1; wa0 = a0; wa1 = a1; wa2 = a2; wa3 = a3; wd = d;
        step();
        wr_en = 0;
    endtask

    task automatic pixel(input logic [7:0] r, g, b);
        rd_en = 1; ra_r = r; ra_g = g; ra_b = b;
        step();
        rd_en = 0;
    endtask

    task automatic pulse_wr_done();
        wr_done = 1; step(); wr_done = 0;
    endtask

    task automatic pulse_rd_done();
        rd_done = 1; step(); rd_done = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    // Four distinct lane addresses; roughly one in nine is out of range.
    task automatic rand_lanes(output logic [7:0] a [4]);
        for (int l = 0; l < 4; l++) begin
            bit dup;
            do begin
                a[l] = 8'($urandom_range(0, 215));
                dup = 0;
                for (int m = 0; m < l; m++) if (a[m] == a[l]) dup = 1;
            end while (dup);
        end
    endtask

    initial begin
        logic [7:0] a [4];
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < C_BYTES; i++) mdl_known[b][i] = 0;
        idle();
        rst = 1;
        mdl_dknown = 1;

        do_reset();
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_rd_ready", 32'(rd_ready), 32'd0);

        // Deterministic fill: byte value equals its address.
        for (int k = 0; k < C_BEATS; k++)
            beat(8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 32'h03020100 + 32'(k) * 32'h04040404);
        check("fill_count_full", 32'(wr_count), 32'd48);
        pulse_wr_done();
        check("fill_count_clr", 32'(wr_count), 32'd0);
        check("fill_rd_ready", 32'(rd_ready), 32'd1);

        pixel(8'h15, 8'h16, 8'h17);
        check("pixel_151617", 32'(rd_data), 32'h151617);
        for (int i = 0; i < 12; i++) begin
            rd_en = 1;
            ra_r = 8'($urandom_range(0, 191));
            ra_g = 8'($urandom_range(0, 191));
            ra_b = 8'($urandom_range(0, 191));
            step();
        end
        rd_en = 0;
        step();
        check("err_clean", 32'(err), 32'd0);

        // Fill bank 1, then attempt a write with both banks full.
        for (int k = 0; k < C_BEATS; k++)
            beat(8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3), $urandom);
        pulse_wr_done();
        check("both_full_wr_ready", 32'(wr_ready), 32'd0);
        beat(8'h20, 8'h21, 8'h22, 8'h23, 32'hDEADBEEF);
        check("blocked_write_err", 32'(err), 32'd1);
        pixel(8'h20, 8'h21, 8'h22);
        check("blocked_write_nomem", 32'(rd_data), 32'h202122);
        pulse_rd_done();
        check("release_wr_ready", 32'(wr_ready), 32'd1);

        // Bank 1 full for reading, bank 0 filling: close and release together.
        for (int k = 0; k < 5; k++) beat(8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3), $urandom);
        wr_done = 1; rd_done = 1; rd_en = 1; ra_r = 8'h01; ra_g = 8'h02; ra_b = 8'h03;
        step();
        wr_done = 0; rd_done = 0; rd_en = 0;
        check("simul_wr_ready", 32'(wr_ready), 32'd1);
        check("simul_rd_ready", 32'(rd_ready), 32'd1);

        // Range handling after a clean reset.
        do_reset();
        beat(8'h00, 8'h01, 8'hC0, 8'h03, 32'hDDCCBBAA);
        check("range_wr_err", 32'(err), 32'd1);
        pulse_wr_done();
        pixel(8'hC5, 8'h00, 8'h03);
        check("range_rd_data", 32'(rd_data), 32'h00AADD);

        // Reset mid-fill clears status including the sticky error.
        do_reset();
        for (int k = 0; k < 20; k++)
            beat(8'(4*k), 8'(4*k+1), (k == 7) ? 8'hF0 : 8'(4*k+2), 8'(4*k+3), $urandom);
        check("midfill_count", 32'(wr_count), 32'd20);
        check("midfill_err", 32'(err), 32'd1);
        rst = 1; step(); rst = 0;
        check("rst_count", 32'(wr_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_lanes(a);
            rst     = ($urandom_range(0, 399) == 0);
            wr_en   = ($urandom_range(0, 9) < 6);
            wa0 = a[0]; wa1 = a[1]; wa2 = a[2]; wa3 = a[3]; wd = $urandom;
            wr_done = ($urandom_range(0, 29) == 0);
            rd_en   = ($urandom_range(0, 1) == 0);
            ra_r = 8'($urandom_range(0, 199));
            ra_g = 8'($urandom_range(0, 199));
            ra_b = 8'($urandom_range(0, 199));
            rd_done = ($urandom_range(0, 29) == 0);
            step();
        end
        idle();
        rst = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
